// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter
// Shares one combinational single-precision FP adder among NUM_REQ requesters.
// A round-robin arbiter accepts one request while idle and loads its operands
// into registers driving the adder. ADD_LAT cycles later the sum is captured
// and returned on a valid/ready response channel tagged with the requester id.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst_n       synchronous active-low reset
//   req_valid   per-requester request
//   req_ready   one-hot accept strobe, only ever high while idle
//   req_a/req_b packed operands, requester i at [i*WIDTH +: WIDTH]
//   add_a/add_b registered operands into the adder
//   add_result  adder sum
//   rsp_valid   response valid
//   rsp_ready   response consumer ready
//   rsp_id      index of the requester owning the response
//   rsp_result  registered sum
//   busy        high whenever a job is in flight or awaiting its handshake
module fp_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADD_LAT = 1,
  parameter int WIDTH   = 32,
  localparam int ID_W   = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  input  logic [WIDTH-1:0]         add_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     busy
);

  // ADD_LAT tops out at 15, so the countdown never needs more than 4 bits.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } stateT;

  stateT             stateR;
  stateT             nextStateS;
  logic [ID_W-1:0]   lastGrantR;
  logic [CNT_W-1:0]  cntR;
  logic [WIDTH-1:0]  addAR;
  logic [WIDTH-1:0]  addBR;
  logic [WIDTH-1:0]  rspResultR;
  logic [ID_W-1:0]   rspIdR;

  int                bestDistS;
  int                distS;
  logic              hitS;
  logic              grantFoundS;
  logic [ID_W-1:0]   grantIdxS;
  logic [WIDTH-1:0]  selAS;
  logic [WIDTH-1:0]  selBS;

  // Round-robin pick: the valid requester with the smallest wrap distance past
  // lastGrantR wins; its operand slices are selected alongside.
  always_comb begin
    bestDistS   = NUM_REQ;
    distS       = 0;
    hitS        = 1'b0;
    grantFoundS = 1'b0;
    grantIdxS   = '0;
    selAS       = '0;
    selBS       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      distS       = (i + NUM_REQ - 1 - int'(lastGrantR)) % NUM_REQ;
      hitS        = req_valid[i] && (distS < bestDistS);
      bestDistS   = hitS ? distS : bestDistS;
      grantFoundS = grantFoundS | hitS;
      grantIdxS   = hitS ? ID_W'(i) : grantIdxS;
      selAS       = hitS ? req_a[i*WIDTH +: WIDTH] : selAS;
      selBS       = hitS ? req_b[i*WIDTH +: WIDTH] : selBS;
    end
  end

  // Grant strobe: one-hot on the winner while idle, masked during reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && (stateR == IDLE) && grantFoundS) begin
      req_ready = NUM_REQ'(1) << grantIdxS;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state decode.
  always_comb begin
    nextStateS = stateR;
    case (stateR)
      IDLE: begin
        if (grantFoundS) nextStateS = WAIT;
        else             nextStateS = IDLE;
      end
      WAIT: begin
        if (cntR == '0) nextStateS = RESP;
        else            nextStateS = WAIT;
      end
      RESP: begin
        if (rsp_ready) nextStateS = IDLE;
        else           nextStateS = RESP;
      end
      default: nextStateS = IDLE;
    endcase
  end

  // State, operand, countdown and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateR     <= IDLE;
      lastGrantR <= ID_W'(NUM_REQ - 1);
      cntR       <= '0;
      addAR      <= '0;
      addBR      <= '0;
      rspResultR <= '0;
      rspIdR     <= '0;
    end else begin
      stateR <= nextStateS;
      case (stateR)
        IDLE: begin
          if (grantFoundS) begin
            addAR      <= selAS;
            addBR      <= selBS;
            rspIdR     <= grantIdxS;
            lastGrantR <= grantIdxS;
            cntR       <= CNT_W'(ADD_LAT - 1);
          end
        end
        WAIT: begin
          // The sum is sampled only in the last WAIT cycle; earlier values
          // on add_result are still settling and are ignored.
          if (cntR == '0) rspResultR <= add_result;
          else            cntR       <= cntR - CNT_W'(1);
        end
        default: begin
          cntR <= cntR;
        end
      endcase
    end
  end

  assign add_a      = addAR;
  assign add_b      = addBR;
  assign rsp_id     = rspIdR;
  assign rsp_result = rspResultR;
  assign rsp_valid  = (stateR == RESP);
  assign busy       = (stateR != IDLE);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Self-checking bench for fp_add_arbiter: directed vector table, hand-written
// multi-cycle sequences, an ADD_LAT=3 instance, and randomized traffic checked
// against a transaction-level reference model.
module tb_fp_add_arbiter;
  localparam int N   = 4;
  localparam int W   = 32;
  localparam int LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // main instance (ADD_LAT=1)
  logic           rstN;
  logic [N-1:0]   reqValid, reqReady;
  logic [N*W-1:0] reqA, reqB;
  logic [W-1:0]   addA, addB, addResult, rspResult;
  logic           rspValid, rspReady, busy;
  logic [1:0]     rspId;

  // ADD_LAT=3 instance
  logic           rst3;
  logic [N-1:0]   valid3, ready3;
  logic [N*W-1:0] a3, b3;
  logic [W-1:0]   addA3, addB3, addResult3, rspResult3, ovr3Val;
  logic           rspValid3, rspReady3, busy3, ovr3En;
  logic [1:0]     rspId3;

  // Adder stub: 1.0 + 2.0 gives the real sum, anything else a fixed mix.
  function automatic logic [31:0] stubAdd(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    return a + b + 32'h00000101;
  endfunction

  assign addResult  = stubAdd(addA, addB);
  assign addResult3 = ovr3En ? ovr3Val : stubAdd(addA3, addB3);

  fp_add_arbiter #(.NUM_REQ(N), .ADD_LAT(LAT), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rstN), .req_valid(reqValid), .req_ready(reqReady),
    .req_a(reqA), .req_b(reqB), .add_a(addA), .add_b(addB),
    .add_result(addResult), .rsp_valid(rspValid), .rsp_ready(rspReady),
    .rsp_id(rspId), .rsp_result(rspResult), .busy(busy));

  fp_add_arbiter #(.NUM_REQ(N), .ADD_LAT(3), .WIDTH(W)) dut3 (
    .clk(clk), .rst_n(rst3), .req_valid(valid3), .req_ready(ready3),
    .req_a(a3), .req_b(b3), .add_a(addA3), .add_b(addB3),
    .add_result(addResult3), .rsp_valid(rspValid3), .rsp_ready(rspReady3),
    .rsp_id(rspId3), .rsp_result(rspResult3), .busy(busy3));

  // completed responses of the main instance, in handshake order
  int rspLog[$];
  always @(negedge clk) if (rspValid && rspReady) rspLog.push_back(int'(rspId));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic int onehotIdx(input logic [N-1:0] v);
    if ($countones(v) != 1) return 99;
    for (int i = 0; i < N; i++) if (((v >> i) & 4'b0001) != 4'b0000) return i;
    return 99;
  endfunction

  function automatic logic [31:0] sliceOf(input logic [N*W-1:0] v, input int i);
    return 32'(v >> (i * W));
  endfunction

  // Reference arbitration: scan upward from last+1 with wrap-around.
  function automatic int rrPick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (((v >> ((last + k) % N)) & 4'b0001) != 4'b0000) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic doReset();
    rstN = 1'b0; reqValid = '1; rspReady = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset.readyForcedLow", 32'(reqReady), 32'h0);
    @(posedge clk); #1;
    reqValid = '0; rstN = 1'b1;
  endtask

  // Waits (bounded) for a grant; returns at the cycle after it, idx=-1 on timeout.
  task automatic waitGrant(output int idx, output int at);
    idx = -1; at = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (reqReady != '0) begin
        idx = onehotIdx(reqReady); at = cycle;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idleCycles(input int n);
    reqValid = '0;
    for (int k = 0; k < n; k++) begin @(posedge clk); #1; end
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  expReady;
    int          expId;
    logic [31:0] expResult;
  } vecT;

  vecT vecs[6];

  task automatic runTable();
    vecs[0] = '{4'b0001, 32'h3F800000, 32'h40000000, 4'b0001, 0, 32'h40400000};
    vecs[1] = '{4'b0101, 32'h12345678, 32'h0F0F0F0F, 4'b0100, 2, 32'h0};
    vecs[2] = '{4'b0101, 32'h80000000, 32'h00000001, 4'b0001, 0, 32'h0};
    vecs[3] = '{4'b1000, 32'hFFFFFFFF, 32'h00000002, 4'b1000, 3, 32'h0};
    vecs[4] = '{4'b0110, 32'h41200000, 32'hC1200000, 4'b0010, 1, 32'h0};
    vecs[5] = '{4'b0010, 32'h7F7FFFFF, 32'h00800000, 4'b0010, 1, 32'h0};
    for (int v = 1; v < 6; v++) vecs[v].expResult = stubAdd(vecs[v].a, vecs[v].b);
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < N; i++) begin
        reqA[i*W +: W] = vecs[v].a ^ (32'(i ^ vecs[v].expId) << 24);
        reqB[i*W +: W] = vecs[v].b ^ (32'(i ^ vecs[v].expId) << 16);
      end
      reqValid = vecs[v].valid; rspReady = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d.ready", v), 32'(reqReady), 32'(vecs[v].expReady));
      chk($sformatf("vec%0d.busyIdle", v), 32'(busy), 32'h0);
      @(posedge clk); #1;
      reqValid = '0; reqA = {N{32'hDEADBEEF}}; reqB = {N{32'hCAFEF00D}};
      @(negedge clk);
      chk($sformatf("vec%0d.addA", v), addA, vecs[v].a);
      chk($sformatf("vec%0d.addB", v), addB, vecs[v].b);
      chk($sformatf("vec%0d.waitNoRsp", v), {31'h0, rspValid}, 32'h0);
      chk($sformatf("vec%0d.waitNoReady", v), 32'(reqReady), 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("vec%0d.rspValid", v), {31'h0, rspValid}, 32'h1);
      chk($sformatf("vec%0d.rspId", v), 32'(rspId), 32'(vecs[v].expId));
      chk($sformatf("vec%0d.rspResult", v), rspResult, vecs[v].expResult);
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("vec%0d.backIdle", v), {30'h0, rspValid, busy}, 32'h0);
      @(posedge clk); #1;
    end
  endtask

  int gIdx[6], gAt[6];
  int expRr[6] = '{0, 1, 2, 3, 0, 1};

  task automatic runRoundRobinAndStall();
    int g, t;
    doReset();
    for (int i = 0; i < N; i++) begin
      reqA[i*W +: W] = 32'h11111111 * 32'(i + 1);
      reqB[i*W +: W] = 32'h01020304 << i;
    end
    reqValid = 4'b1111; rspReady = 1'b1; rspLog.delete();
    for (int k = 0; k < 6; k++) waitGrant(gIdx[k], gAt[k]);
    for (int k = 0; k < 6; k++) chk($sformatf("rr.grant%0d", k), 32'(gIdx[k]), 32'(expRr[k]));
    for (int k = 1; k < 6; k++) chk($sformatf("rr.spacing%0d", k), 32'(gAt[k] - gAt[k-1]), 32'd3);
    for (int k = 0; k < 10 && rspLog.size() < 6; k++) begin @(posedge clk); #1; end
    chk("rr.rspCount", 32'(rspLog.size()), 32'd6);
    for (int k = 0; k < 6 && k < rspLog.size(); k++)
      chk($sformatf("rr.rspId%0d", k), 32'(rspLog[k]), 32'(expRr[k]));
    // back-pressure on the job of requester 2
    waitGrant(g, t);
    chk("bp.grant", 32'(g), 32'd2);
    rspReady = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp.valid%0d", k), {31'h0, rspValid}, 32'h1);
      chk($sformatf("bp.id%0d", k), 32'(rspId), 32'd2);
      chk($sformatf("bp.result%0d", k), rspResult, stubAdd(32'h33333333, 32'h04080C10));
      chk($sformatf("bp.noReady%0d", k), 32'(reqReady), 32'h0);
      chk($sformatf("bp.addA%0d", k), addA, 32'h33333333);
      @(posedge clk); #1;
    end
    rspReady = 1'b1;
    @(negedge clk);
    chk("bp.handshakeValid", {31'h0, rspValid}, 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp.nextAccept", 32'(reqReady), 32'b1000);
    @(posedge clk); #1;
    idleCycles(4);
  endtask

  task automatic runResetInWait();
    reqValid = 4'b0010; rspReady = 1'b1;
    @(negedge clk);
    chk("rstw.grant", 32'(reqReady), 32'b0010);
    @(posedge clk); #1;
    reqValid = '0; rstN = 1'b0; rspLog.delete();
    @(posedge clk); #1;
    rstN = 1'b1; reqValid = 4'b0101;
    @(negedge clk);
    chk("rstw.idle", {30'h0, rspValid, busy}, 32'h0);
    chk("rstw.addA", addA, 32'h0);
    chk("rstw.addB", addB, 32'h0);
    chk("rstw.req0Wins", 32'(reqReady), 32'b0001);
    @(posedge clk); #1;
    reqValid = '0;
    for (int k = 0; k < 5; k++) begin @(posedge clk); #1; end
    chk("rstw.rspCount", 32'(rspLog.size()), 32'd1);
    if (rspLog.size() > 0) chk("rstw.rspId", 32'(rspLog[0]), 32'd0);
  endtask

  task automatic runSole();
    int g[5], t[5];
    rspReady = 1'b1; reqValid = 4'b0100;
    for (int k = 0; k < 3; k++) waitGrant(g[k], t[k]);
    reqValid = 4'b1100;
    waitGrant(g[3], t[3]);
    waitGrant(g[4], t[4]);
    for (int k = 0; k < 3; k++) chk($sformatf("sole.grant%0d", k), 32'(g[k]), 32'd2);
    chk("sole.newcomer", 32'(g[3]), 32'd3);
    chk("sole.after", 32'(g[4]), 32'd2);
    for (int k = 1; k < 5; k++) chk($sformatf("sole.spacing%0d", k), 32'(t[k] - t[k-1]), 32'd3);
    idleCycles(4);
  endtask

  task automatic runLat3();
    rst3 = 1'b0; valid3 = '0; rspReady3 = 1'b0; ovr3En = 1'b0; ovr3Val = '0;
    for (int i = 0; i < N; i++) begin
      a3[i*W +: W] = 32'h40A00000 + 32'(i);
      b3[i*W +: W] = 32'h3F000000 + 32'(i);
    end
    @(posedge clk); #1; @(posedge clk); #1;
    rst3 = 1'b1; valid3 = 4'b0001;
    @(negedge clk);
    chk("lat3.ready", 32'(ready3), 32'b0001);
    @(posedge clk); #1;
    valid3 = '0; ovr3En = 1'b1; ovr3Val = 32'h11111111;
    @(negedge clk);
    chk("lat3.noRspT1", {31'h0, rspValid3}, 32'h0);
    chk("lat3.addA", addA3, 32'h40A00000);
    @(posedge clk); #1; ovr3Val = 32'h22222222;
    @(negedge clk);
    chk("lat3.noRspT2", {31'h0, rspValid3}, 32'h0);
    @(posedge clk); #1; ovr3Val = 32'hC0FFEE00;
    @(negedge clk);
    chk("lat3.noRspT3", {31'h0, rspValid3}, 32'h0);
    @(posedge clk); #1; ovr3Val = 32'h33333333;
    @(negedge clk);
    chk("lat3.rspT4", {31'h0, rspValid3}, 32'h1);
    chk("lat3.result", rspResult3, 32'hC0FFEE00);
    chk("lat3.id", 32'(rspId3), 32'h0);
    @(posedge clk); #1; rspReady3 = 1'b1;
    @(negedge clk);
    chk("lat3.hold", rspResult3, 32'hC0FFEE00);
    @(posedge clk); #1; ovr3En = 1'b0;
    @(negedge clk);
    chk("lat3.done", {30'h0, rspValid3, busy3}, 32'h0);
    @(posedge clk); #1;
  endtask

  // Transaction-level model: a job exists from its accept cycle until its
  // handshake; its response is visible from LAT+1 cycles after acceptance.
  task automatic runRandom(input int n);
    bit          mHas = 1'b0;
    int          mId = 0, mAcc = 0, mLast = N - 1, mLastId = 0, g;
    logic [31:0] mA = '0, mB = '0, mRes = '0, mLastA = '0, mLastB = '0, mRspResult = '0;
    bit          resp;
    doReset();
    for (int c = 0; c < n; c++) begin
      reqValid = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        reqA[i*W +: W] = $urandom;
        reqB[i*W +: W] = $urandom;
      end
      rspReady = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (!mHas) begin
        g = rrPick(reqValid, mLast);
        chk("rand.ready", 32'(reqReady), (g >= 0) ? (32'h1 << g) : 32'h0);
        chk("rand.idleFlags", {30'h0, rspValid, busy}, 32'h0);
        chk("rand.addA", addA, mLastA);
        chk("rand.addB", addB, mLastB);
        chk("rand.rspId", 32'(rspId), 32'(mLastId));
        chk("rand.rspResult", rspResult, mRspResult);
        if (g >= 0) begin
          mHas = 1'b1; mId = g; mAcc = cycle; mLast = g; mLastId = g;
          mA = sliceOf(reqA, g); mB = sliceOf(reqB, g); mRes = stubAdd(mA, mB);
          mLastA = mA; mLastB = mB;
        end
      end else begin
        resp = (cycle - mAcc) >= LAT + 1;
        chk("rand.readyBusy", 32'(reqReady), 32'h0);
        chk("rand.busyFlags", {30'h0, rspValid, busy}, {30'h0, resp, 1'b1});
        chk("rand.addA", addA, mA);
        chk("rand.addB", addB, mB);
        chk("rand.rspId", 32'(rspId), 32'(mId));
        chk("rand.rspResult", rspResult, resp ? mRes : mRspResult);
        if (resp && rspReady) begin
          mHas = 1'b0; mRspResult = mRes;
        end
      end
      @(posedge clk); #1;
    end
    idleCycles(4);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst3 = 1'b0; valid3 = '0; rspReady3 = 1'b0; ovr3En = 1'b0; ovr3Val = '0;
    a3 = '0; b3 = '0; reqA = '0; reqB = '0;
    doReset();
    @(negedge clk);
    chk("reset.addA", addA, 32'h0);
    chk("reset.addB", addB, 32'h0);
    chk("reset.rspResult", rspResult, 32'h0);
    chk("reset.rspId", 32'(rspId), 32'h0);
    chk("reset.flags", {30'h0, rspValid, busy}, 32'h0);
    chk("reset.ready", 32'(reqReady), 32'h0);
    @(posedge clk); #1;
    runTable();
    runRoundRobinAndStall();
    runResetInWait();
    runSole();
    runLat3();
    runRandom(400);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_add_arbiter.md
Name: fp_add_arbiter

Overview:
- Shares one single-precision floating-point adder datapath (32-bit operands A/B, 32-bit result) among NUM_REQ requesters.
- Round-robin arbitration selects a requester and latches its operands into registers that drive the adder.
- After ADD_LAT cycles, the adder result is captured and returned on a valid/ready response channel tagged with the requester index.
- Sits between the requesting units and the combinational FP add datapath.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..16.
- ADD_LAT, 1: cycles from add_a/add_b being driven to add_result being valid; legal range 1..15.
- WIDTH, 32: operand/result width (IEEE-754 single).
- Derived localparam ID_W = max(1, clog2(NUM_REQ)).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_ready  out  NUM_REQ  one-hot grant/accept strobe.
- req_a  in  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  operand B; same packing as req_a.
- add_a  out  WIDTH  registered operand A to the adder.
- add_b  out  WIDTH  registered operand B to the adder.
- add_result  in  WIDTH  adder sum.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_result  out  WIDTH  registered sum.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, WAIT, RESP.
- Reset (rst_n low at a clock edge):
  - state=IDLE; last_grant=NUM_REQ-1, so requester 0 has first priority.
  - add_a=0, add_b=0, rsp_result=0, rsp_id=0, cnt=0.
  - req_ready is forced 0 while rst_n is low.
- Reset mid-operation: any in-flight transaction is discarded and no response is issued.
- IDLE, arbitration:
  - g = first i with req_valid[i]=1, scanning from (last_grant+1) mod NUM_REQ upward with wrap-around.
  - req_ready[g] is asserted combinationally in the same cycle; all other req_ready bits are 0.
  - req_ready is 0 in every state except IDLE.
- IDLE, accept (req_valid[g] & req_ready[g]), at the clock edge:
  - add_a <= req_a slice g; add_b <= req_b slice g.
  - rsp_id <= g; last_grant <= g.
  - cnt <= ADD_LAT-1; state -> WAIT.
  - If no req_valid bit is set, remain in IDLE.
- WAIT:
  - If cnt==0: rsp_result <= add_result; state -> RESP.
  - Otherwise cnt <= cnt-1.
  - add_a/add_b are held constant for the entire WAIT.
  - req_valid changes are ignored.
- RESP:
  - rsp_valid=1, driven registered or decoded from state.
  - rsp_id, rsp_result and add_a/add_b are held stable until rsp_ready=1.
  - On rsp_valid & rsp_ready: state -> IDLE. No new accept occurs in the same cycle.
- Latency and throughput:
  - Accept in cycle T gives rsp_valid first high in cycle T+ADD_LAT+1.
  - Maximum issue rate is one operation per ADD_LAT+2 cycles, plus any back-pressure cycles.
- Requester obligation: req_a/req_b must be stable in the accept cycle only. The block does not require them to be held after acceptance.
- Fairness:
  - A requester that keeps req_valid asserted is granted within NUM_REQ accepts.
  - A sole requester is re-granted consecutively.
- Outputs never carry X after reset; unused ID bits are 0.

Test Plan:
- Lone request: reset, then req_valid=0001, req_a=0x3F800000, req_b=0x40000000 at cycle T -> req_ready=0001 in T only; add_a=0x3F800000 and add_b=0x40000000 from T+1; rsp_valid at T+2 with rsp_id=0 and rsp_result equal to the adder stub output (stub returns 0x40400000).
- All four requesters held valid with rsp_ready=1 -> grant sequence 0,1,2,3,0,1; each rsp_id matches its grant; accepts spaced 3 cycles apart (ADD_LAT=1).
- Back-pressure: rsp_ready=0 for 5 cycles during RESP -> rsp_valid, rsp_id and rsp_result stable; req_ready stays 0000 although req_valid=1111; release yields accept of the next requester 1 cycle after the handshake.
- ADD_LAT=3 build -> rsp_result equals the add_result sampled in cycle T+3; rsp_valid first high at T+4; a mid-WAIT change on add_result before T+3 has no effect.
- Reset during WAIT: rst_n low for 1 cycle -> next cycle state IDLE, rsp_valid=0, add_a=0, no response ever issued for that job; next request from requester 2 with requester 0 also valid -> requester 0 wins.
- Sole requester: only req_valid[2]=1 continuously -> consecutive grants to 2 with no idle cycles beyond the protocol minimum; requester 3 then asserting is granted before requester 2 is granted again.
